countdown_ctrl: RTL

Control and scheduling block for the board countdown timer. It owns the MM:SS time value in BCD and runs a start/pause/clear state machine from pre-debounced button pulses. It also generates the 1 s decrement tick and time-multiplexes the shared 4-digit seven-segment display, emitting one BCD digit plus an active-low digit select. The per-digit segment decoder sits downstream and is not part of this block.

---
 rtl/timer_pkg.sv | 47 ++++
 rtl/bcd_mmss_counter.sv | 45 ++++
 rtl/countdown_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and helpers for the countdown timer: FSM state encoding,
// BCD limits, digit-select patterns and BCD increment/decrement arithmetic.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] SEC_MAX_BCD = 8'h59;
    localparam logic [7:0] MIN_MAX_BCD = 8'h99;

    // Active-low digit selects, indexed by scan slot 0..3
    localparam logic [3:0] AN_SEC_ONES = 4'b1110;
    localparam logic [3:0] AN_SEC_TENS = 4'b1101;
    localparam logic [3:0] AN_MIN_ONES = 4'b1011;
    localparam logic [3:0] AN_MIN_TENS = 4'b0111;

    // Two-digit BCD +1, wrapping from max back to 00
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        logic [7:0] r;
        if (v == max) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Two-digit BCD -1, wrapping from 00 to max
    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
        logic [7:0] r;
        if (v == 8'h00) begin
            r = max;
        end else if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_mmss_counter.sv
// MM:SS time register in BCD.
// Ports: clk, rst (sync, active-high); load reloads defaults; dec counts down
// one second (SS borrows from MM, 00:00 holds); inc_min/inc_sec bump each
// field independently with wrap; min_bcd/sec_bcd are the registered time;
// zero_next flags that a decrement now would land on 00:00.
module bcd_mmss_counter
    import timer_pkg::*;
#(
    parameter logic [7:0] DEFAULT_MIN_BCD = 8'h03,
    parameter logic [7:0] DEFAULT_SEC_BCD = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       dec,
    input  logic       inc_min,
    input  logic       inc_sec,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       zero_next
);

    // Time register: load beats dec beats inc
    always_ff @(posedge clk) begin
        if (rst || load) begin
            min_bcd <= DEFAULT_MIN_BCD;
            sec_bcd <= DEFAULT_SEC_BCD;
        end else if (dec) begin
            if (sec_bcd == 8'h00) begin
                if (min_bcd != 8'h00) begin
                    sec_bcd <= SEC_MAX_BCD;
                    min_bcd <= bcd_dec(min_bcd, MIN_MAX_BCD);
                end
            end else begin
                sec_bcd <= bcd_dec(sec_bcd, SEC_MAX_BCD);
            end
        end else begin
            if (inc_min) min_bcd <= bcd_inc(min_bcd, MIN_MAX_BCD);
            if (inc_sec) sec_bcd <= bcd_inc(sec_bcd, SEC_MAX_BCD);
        end
    end

    assign zero_next = (min_bcd == 8'h00) && (sec_bcd == 8'h01);

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown timer control: start/pause/clear FSM, 1 s tick divider and
// 4-digit display scanner over an MM:SS BCD time register.
// Ports: clk, rst (sync, active-high); start_i/pause_i/clear_i/inc_min_i/
// inc_sec_i single-cycle command pulses; min_bcd/sec_bcd current time;
// running/expired state flags; an active-low digit select; digit_bcd the
// BCD digit for the selected position. All outputs registered.
module countdown_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV        = 100_000_000,
    parameter int unsigned SCAN_DIV        = 100_000,
    parameter logic [7:0]  DEFAULT_MIN_BCD = 8'h03,
    parameter logic [7:0]  DEFAULT_SEC_BCD = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       pause_i,
    input  logic       clear_i,
    input  logic       inc_min_i,
    input  logic       inc_sec_i,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       expired,
    output logic [3:0] an,
    output logic [3:0] digit_bcd
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    state_t            state;
    state_t            state_next;
    logic [TICK_W-1:0] tick_cnt;
    logic [SCAN_W-1:0] scan_cnt;
    logic [1:0]        scan_idx;
    logic [1:0]        scan_idx_next;
    logic [3:0]        an_next;
    logic [3:0]        digit_next;
    logic              tick;
    logic              tick_clr;
    logic              load;
    logic              dec;
    logic              inc_min;
    logic              inc_sec;
    logic              zero_next;
    logic              time_zero;

    bcd_mmss_counter #(
        .DEFAULT_MIN_BCD (DEFAULT_MIN_BCD),
        .DEFAULT_SEC_BCD (DEFAULT_SEC_BCD)
    ) u_time (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .dec       (dec),
        .inc_min   (inc_min),
        .inc_sec   (inc_sec),
        .min_bcd   (min_bcd),
        .sec_bcd   (sec_bcd),
        .zero_next (zero_next)
    );

    assign time_zero = (min_bcd == 8'h00) && (sec_bcd == 8'h00);
    assign tick      = (state == ST_RUN) && (tick_cnt == TICK_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and time-register controls. One command wins per cycle
    // (clear > pause > start > inc); pause outranks start even where pause
    // itself has no effect. The tick is not a command, so it still acts
    // alongside a pause in RUN.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        dec        = 1'b0;
        inc_min    = 1'b0;
        inc_sec    = 1'b0;
        tick_clr   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (clear_i) begin
                    load = 1'b1;
                end else if (pause_i) begin
                    state_next = ST_IDLE;
                end else if (start_i) begin
                    if (!time_zero) begin
                        state_next = ST_RUN;
                        tick_clr   = 1'b1;
                    end
                end else begin
                    inc_min = inc_min_i;
                    inc_sec = inc_sec_i;
                end
            end
            ST_RUN: begin
                if (clear_i) begin
                    load       = 1'b1;
                    tick_clr   = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    dec = tick;
                    if (tick && zero_next) begin
                        state_next = ST_DONE;
                    end else if (pause_i) begin
                        state_next = ST_PAUSE;
                    end
                end
            end
            ST_PAUSE: begin
                if (clear_i) begin
                    load       = 1'b1;
                    tick_clr   = 1'b1;
                    state_next = ST_IDLE;
                end else if (!pause_i && start_i) begin
                    state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                if (clear_i || (!pause_i && start_i)) begin
                    load       = 1'b1;
                    tick_clr   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Status flags track the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            expired <= 1'b0;
        end else begin
            running <= (state_next == ST_RUN);
            expired <= (state_next == ST_DONE);
        end
    end

    // Second divider: counts RUN cycles only, so pause keeps the partial second
    always_ff @(posedge clk) begin
        if (rst || tick_clr) begin
            tick_cnt <= '0;
        end else if (state == ST_RUN) begin
            tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
        end
    end

    // Scan slot selection and digit mux for the slot about to be shown
    always_comb begin
        scan_idx_next = (scan_cnt == SCAN_LAST) ? scan_idx + 2'd1 : scan_idx;
        an_next       = AN_SEC_ONES;
        digit_next    = sec_bcd[3:0];
        case (scan_idx_next)
            2'd0: begin an_next = AN_SEC_ONES; digit_next = sec_bcd[3:0]; end
            2'd1: begin an_next = AN_SEC_TENS; digit_next = sec_bcd[7:4]; end
            2'd2: begin an_next = AN_MIN_ONES; digit_next = min_bcd[3:0]; end
            2'd3: begin an_next = AN_MIN_TENS; digit_next = min_bcd[7:4]; end
            default: begin an_next = AN_SEC_ONES; digit_next = sec_bcd[3:0]; end
        endcase
    end

    // Free-running scanner; an and digit_bcd register on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt  <= '0;
            scan_idx  <= 2'd0;
            an        <= AN_SEC_ONES;
            digit_bcd <= DEFAULT_SEC_BCD[3:0];
        end else begin
            scan_cnt  <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + SCAN_W'(1);
            scan_idx  <= scan_idx_next;
            an        <= an_next;
            digit_bcd <= digit_next;
        end
    end

endmodule
